// File: rtl/puf_majority_sampler.sv
// Challenge/settle/sample controller for arbiter PUF banks with a per-channel majority vote.
// Optional macro PUF_STABILITY_EN adds the per-channel unanimity flags on `stable`.
module puf_majority_sampler #(
  parameter int N_CH       = 4,
  parameter int CH_W       = 4,
  parameter int N_SAMP     = 7,
  parameter int SETTLE_CYC = 8,
  parameter int SAMP_GAP   = 4,
  parameter int AUTO       = 1,
  parameter int PERIOD     = 50000000
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [N_CH*CH_W-1:0]   SW,
  input  logic                   start,
  input  logic [N_CH-1:0]        raw_resp,
  output logic [N_CH*CH_W-1:0]   chal_out,
  output logic                   busy,
  output logic                   valid,
  output logic [N_CH-1:0]        resp,
  output logic [N_CH-1:0]        stable
);

  localparam int OW   = $clog2(N_SAMP + 1);
  localparam int PW   = $clog2(PERIOD);
  localparam int CMAX = (SETTLE_CYC > SAMP_GAP) ? SETTLE_CYC : SAMP_GAP;
  localparam int CW   = $clog2(CMAX);

  localparam logic [PW-1:0] PER_LAST    = PW'(PERIOD - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(SAMP_GAP - 1);
  localparam logic [OW-1:0] SAMP_LAST   = OW'(N_SAMP - 1);
  localparam logic [OW-1:0] HALF        = OW'(N_SAMP / 2);
  localparam logic          AUTO_EN     = (AUTO != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [OW-1:0]             samp_q, samp_d;
  logic [N_CH-1:0][OW-1:0]   ones_q, ones_d;
  logic [PW-1:0]             period_q;
  logic [N_CH-1:0]           sync1_q, sync2_q;
  logic [N_CH*CH_W-1:0]      chal_q;
  logic [N_CH-1:0]           resp_q, vote_d;
  logic                      valid_q;
  logic                      tick, trigger, load_chal, publish;

  assign tick    = (period_q == PER_LAST);
  assign trigger = start | (AUTO_EN & tick);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      period_q <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
    end else begin
      period_q <= tick ? '0 : period_q + PW'(1);
      sync1_q  <= raw_resp;
      sync2_q  <= sync1_q;
    end
  end

  // publish fires on the edge of the last sample so valid/resp appear during DONE
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    samp_d    = samp_q;
    ones_d    = ones_q;
    load_chal = 1'b0;
    publish   = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          load_chal = 1'b1;
          ones_d    = '0;
          cnt_d     = '0;
          samp_d    = '0;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SAMPLE: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          for (int i = 0; i < N_CH; i++) begin
            ones_d[i] = ones_q[i] + OW'(sync2_q[i]);
          end
          if (samp_q == SAMP_LAST) begin
            publish = 1'b1;
            state_d = DONE;
          end else begin
            samp_d = samp_q + OW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    vote_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      vote_d[i] = (ones_d[i] > HALF);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      samp_q  <= '0;
      ones_q  <= '0;
      chal_q  <= '0;
      resp_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      samp_q  <= samp_d;
      ones_q  <= ones_d;
      valid_q <= publish;
      if (load_chal) chal_q <= SW;
      if (publish)   resp_q <= vote_d;
    end
  end

`ifdef PUF_STABILITY_EN
  localparam logic [OW-1:0] ALL = OW'(N_SAMP);
  logic [N_CH-1:0] unan_d, stable_q;

  always_comb begin
    unan_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      unan_d[i] = (ones_d[i] == '0) || (ones_d[i] == ALL);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)       stable_q <= '0;
    else if (publish) stable_q <= unan_d;
  end

  assign stable = stable_q;
`else
  assign stable = '0;
`endif

  assign chal_out = chal_q;
  assign busy     = (state_q != IDLE);
  assign valid    = valid_q;
  assign resp     = resp_q;

endmodule

// File: tb/tb_puf_majority_sampler.sv
// Directed bench for puf_majority_sampler: manual, noisy, dropped-trigger, reset and auto-tick scenarios.
module tb_puf_majority_sampler;

`ifdef PUF_STABILITY_EN
  localparam logic STAB_EN = 1'b1;
`else
  localparam logic STAB_EN = 1'b0;
`endif

  logic        CLK;
  logic        RST_N;
  logic [15:0] sw;
  logic        start;
  logic [3:0]  raw_resp;
  logic [15:0] chal_out;
  logic        busy, valid;
  logic [3:0]  resp, stable;

  logic        rst_a_n;
  logic [15:0] sw_a;
  logic        start_a;
  logic [3:0]  raw_a;
  logic [15:0] chal_a;
  logic        busy_a, valid_a;
  logic [3:0]  resp_a, stable_a;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  puf_majority_sampler #(
    .N_CH(4), .CH_W(4), .N_SAMP(5), .SETTLE_CYC(4), .SAMP_GAP(2), .AUTO(0), .PERIOD(64)
  ) u_dut (
    .CLK(CLK), .RST_N(RST_N), .SW(sw), .start(start), .raw_resp(raw_resp),
    .chal_out(chal_out), .busy(busy), .valid(valid), .resp(resp), .stable(stable)
  );

  puf_majority_sampler #(
    .N_CH(4), .CH_W(4), .N_SAMP(5), .SETTLE_CYC(4), .SAMP_GAP(2), .AUTO(1), .PERIOD(64)
  ) u_auto (
    .CLK(CLK), .RST_N(rst_a_n), .SW(sw_a), .start(start_a), .raw_resp(raw_a),
    .chal_out(chal_a), .busy(busy_a), .valid(valid_a), .resp(resp_a), .stable(stable_a)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    RST_N = 1'b0; rst_a_n = 1'b0;
    sw = '0; start = 1'b0; raw_resp = '0;
    sw_a = 16'hBEEF; start_a = 1'b0; raw_a = 4'b0110;
    repeat (3) @(negedge CLK);
    checks++; if (chal_out !== 16'h0) begin errors++; $display("FAIL reset_chal: got %h expected %h", chal_out, 16'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (resp !== 4'h0) begin errors++; $display("FAIL reset_resp: got %b expected 0000", resp); end
    checks++; if (stable !== 4'h0) begin errors++; $display("FAIL reset_stable: got %b expected 0000", stable); end
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_manual();
    int n;
    logic [3:0] exp_st;
    exp_st = STAB_EN ? 4'b1111 : 4'b0000;
    sw = 16'hA5C3; raw_resp = 4'b1010;
    repeat (3) @(negedge CLK);
    start = 1'b1;                          // cycle T
    @(negedge CLK); start = 1'b0;          // T+1
    checks++; if (chal_out !== 16'hA5C3) begin errors++; $display("FAIL manual_chal: got %h expected a5c3", chal_out); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL manual_busy_t1: got %b expected 1", busy); end
    n = 0;
    for (int i = 2; i <= 14; i++) begin
      @(negedge CLK);
      if (valid) n++;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL manual_early_valid: got %0d expected 0", n); end
    @(negedge CLK);                        // T+15
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL manual_valid: got %b expected 1", valid); end
    checks++; if (resp !== 4'b1010) begin errors++; $display("FAIL manual_resp: got %b expected 1010", resp); end
    checks++; if (stable !== exp_st) begin errors++; $display("FAIL manual_stable: got %b expected %b", stable, exp_st); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL manual_busy_t15: got %b expected 1", busy); end
    @(negedge CLK);                        // T+16
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL manual_busy_t16: got %b expected 0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL manual_valid_pulse: got %b expected 0", valid); end
    checks++; if (resp !== 4'b1010) begin errors++; $display("FAIL manual_resp_hold: got %b expected 1010", resp); end
  endtask

  task automatic test_noisy();
    logic [3:0] pat [5];
    logic [3:0] exp_st;
    pat = '{4'b0101, 4'b0110, 4'b0101, 4'b0100, 4'b0101};
    exp_st = STAB_EN ? 4'b1100 : 4'b0000;
    sw = 16'h1234; raw_resp = 4'b0100;
    @(negedge CLK);
    start = 1'b1;                          // cycle T
    for (int i = 1; i <= 16; i++) begin
      @(negedge CLK);
      if (i == 1) start = 1'b0;
      // sample k lands at T+4+2k; the synchroniser needs two cycles of lead
      if (i >= 4 && i <= 12 && (i % 2) == 0) raw_resp = pat[(i - 4) / 2];
      if (i == 15) begin
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL noisy_valid: got %b expected 1", valid); end
        checks++; if (resp !== 4'b0101) begin errors++; $display("FAIL noisy_resp: got %b expected 0101", resp); end
        checks++; if (stable !== exp_st) begin errors++; $display("FAIL noisy_stable: got %b expected %b", stable, exp_st); end
      end
    end
    checks++; if (chal_out !== 16'h1234) begin errors++; $display("FAIL noisy_chal: got %h expected 1234", chal_out); end
  endtask

  task automatic test_dropped();
    int n, vcyc;
    n = 0; vcyc = -1;
    sw = 16'hA5C3;
    start = 1'b1;                          // cycle T
    for (int i = 1; i <= 30; i++) begin
      @(negedge CLK);
      if (valid) begin n++; vcyc = i; end
      if (i == 1) start = 1'b0;
      if (i == 5) sw = 16'h0001;
      if (i == 6) start = 1'b1;
      if (i == 7) start = 1'b0;
    end
    checks++; if (n != 1) begin errors++; $display("FAIL dropped_count: got %0d expected 1", n); end
    checks++; if (vcyc != 15) begin errors++; $display("FAIL dropped_latency: got %0d expected 15", vcyc); end
    checks++; if (chal_out !== 16'hA5C3) begin errors++; $display("FAIL dropped_chal: got %h expected a5c3", chal_out); end
  endtask

  task automatic test_reset_mid();
    int n, vcyc;
    logic [3:0] exp_st;
    exp_st = STAB_EN ? 4'b1111 : 4'b0000;
    n = 0;
    sw = 16'h5A5A; raw_resp = 4'b0011;
    @(negedge CLK);
    start = 1'b1;                          // cycle T
    for (int i = 1; i <= 24; i++) begin
      @(negedge CLK);
      if (i == 1) start = 1'b0;
      if (i == 8) begin
        RST_N = 1'b0;
        #1;
        checks++; if (chal_out !== 16'h0) begin errors++; $display("FAIL midrst_chal: got %h expected 0000", chal_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (resp !== 4'h0) begin errors++; $display("FAIL midrst_resp: got %b expected 0000", resp); end
        checks++; if (stable !== 4'h0) begin errors++; $display("FAIL midrst_stable: got %b expected 0000", stable); end
      end
      if (i == 11) RST_N = 1'b1;
      if (valid) n++;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL midrst_no_valid: got %0d expected 0", n); end
    start = 1'b1;                          // fresh trigger at T2
    vcyc = -1;
    for (int i = 1; i <= 18; i++) begin
      @(negedge CLK);
      if (i == 1) start = 1'b0;
      if (valid && vcyc < 0) vcyc = i;
    end
    checks++; if (vcyc != 15) begin errors++; $display("FAIL midrst_latency: got %0d expected 15", vcyc); end
    checks++; if (resp !== 4'b0011) begin errors++; $display("FAIL midrst_resp_after: got %b expected 0011", resp); end
    checks++; if (stable !== exp_st) begin errors++; $display("FAIL midrst_stable_after: got %b expected %b", stable, exp_st); end
    checks++; if (chal_out !== 16'h5A5A) begin errors++; $display("FAIL midrst_chal_after: got %h expected 5a5a", chal_out); end
  endtask

  // ticks at cycles 63/127/191 after reset release; valid follows 15 cycles later
  task automatic test_auto();
    int n;
    logic [15:0] exp_c;
    n = 0;
    exp_q.delete();
    exp_q.push_back(16'd78);
    exp_q.push_back(16'd142);
    exp_q.push_back(16'd206);
    @(negedge CLK);
    rst_a_n = 1'b1;                        // cycle 0: period counter at 0
    for (int c = 0; c <= 230; c++) begin
      start_a = (c == 127);
      if (valid_a) begin
        n++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL auto_extra_valid: got valid at cycle %0d expected none", c);
        end else begin
          exp_c = exp_q.pop_front();
          checks++; if (c != int'(exp_c)) begin errors++; $display("FAIL auto_valid_cycle: got %0d expected %0d", c, exp_c); end
          checks++; if (resp_a !== 4'b0110) begin errors++; $display("FAIL auto_resp: got %b expected 0110", resp_a); end
        end
      end
      @(negedge CLK);
    end
    start_a = 1'b0;
    checks++; if (n != 3) begin errors++; $display("FAIL auto_count: got %0d expected 3", n); end
    checks++; if (chal_a !== 16'hBEEF) begin errors++; $display("FAIL auto_chal: got %h expected beef", chal_a); end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_noisy();
    test_dropped();
    test_reset_mid();
    test_auto();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
